// File: rtl/rf_pkg.sv
// Shared constants for the two-write-port register file and its pending-write scoreboard.
package rf_pkg;
  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_ZERO_REG = 0;
endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write busy bits: set on load issue, cleared by load writeback (port 1).
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_busy,
  input  logic [ADDR_W-1:0] busy_addr,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [ADDR_W-1:0] raddr0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic              busy0,
  output logic              busy1
);
  localparam int NREGS = 2**ADDR_W;

  logic [NREGS-1:0] busy;

  // A set and a clear hitting the same register resolve in favour of the set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      for (int i = RF_ZERO_REG + 1; i < NREGS; i++) begin
        if (set_busy && busy_addr == ADDR_W'(i))
          busy[i] <= 1'b1;
        else if (we1 && waddr1 == ADDR_W'(i))
          busy[i] <= 1'b0;
      end
    end
  end

  function automatic logic busy_of(input logic [ADDR_W-1:0] ra);
    logic b;
    b = busy[ra];
    if (BYPASS != 0 && we1 && waddr1 == ra && !(set_busy && busy_addr == ra))
      b = 1'b0;
    if (ra == ADDR_W'(RF_ZERO_REG))
      b = 1'b0;
    return b;
  endfunction

  always_comb begin
    busy0 = busy_of(raddr0);
    busy1 = busy_of(raddr1);
  end
endmodule

// File: rtl/reg_file_2w1b.sv
// Two-write, two-read register file with hardwired zero register, optional
// write-to-read forwarding and a pending-load scoreboard.
module reg_file_2w1b
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] raddr0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy0,
  output logic              busy1,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              set_busy,
  input  logic [ADDR_W-1:0] busy_addr
);
  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];

  // Load writeback (port 1) overrides ALU writeback on an address collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int i = RF_ZERO_REG + 1; i < NREGS; i++) begin
        if (we1 && waddr1 == ADDR_W'(i))
          regs[i] <= wdata1;
        else if (we0 && waddr0 == ADDR_W'(i))
          regs[i] <= wdata0;
      end
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra);
    logic [DATA_W-1:0] val;
    val = regs[ra];
    if (BYPASS != 0) begin
      if (we1 && waddr1 == ra)
        val = wdata1;
      else if (we0 && waddr0 == ra)
        val = wdata0;
    end
    if (ra == ADDR_W'(RF_ZERO_REG))
      val = '0;
    return val;
  endfunction

  always_comb begin
    rdata0 = read_port(raddr0);
    rdata1 = read_port(raddr1);
  end

  rf_scoreboard #(
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_busy  (set_busy),
    .busy_addr (busy_addr),
    .we1       (we1),
    .waddr1    (waddr1),
    .raddr0    (raddr0),
    .raddr1    (raddr1),
    .busy0     (busy0),
    .busy1     (busy1)
  );
endmodule
